// File: rtl/apb_i2c_pkg.sv
// Shared types and constants for the APB-to-I2C-bridge request arbiter.
package apb_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CSETUP,
        CACCESS,
        DSETUP,
        DACCESS,
        RESP
    } state_t;

    localparam logic [31:0] CTRL_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] DATA_ADDR_DEF = 32'hff00_0000;
    localparam logic [7:0]  CON1_DEFAULT  = 8'b1001_1111;

    // con1 field layout, msb first: {ff[1:0], R, D/A, cc[1:0], e, r}
    typedef struct packed {
        logic [1:0] ff;
        logic       r_dir;
        logic       da;
        logic [1:0] cc;
        logic       e;
        logic       r;
    } con1_t;

    typedef struct packed {
        logic [15:0] rsvd;
        logic        rw;
        logic [6:0]  addr;
        con1_t       con1;
    } ctrl_word_t;

    function automatic ctrl_word_t build_ctrl(input logic rw, input logic [6:0] addr,
                                              input logic [7:0] con1);
        ctrl_word_t w;
        w.rsvd = '0;
        w.rw   = rw;
        w.addr = addr;
        w.con1 = con1;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr wins, one-hot plus index out.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_c,
    output logic [IW-1:0]   idx_c
);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                gnt_c[j] = 1'b1;
                idx_c    = IW'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_i2c_arbiter.sv
// Arbitrates NREQ requesters onto one APB master driving an I2C bridge (control then data write/read).
// Optional PREADY watchdog enabled by defining APB_I2C_ARB_TIMEOUT_EN.
module apb_i2c_arbiter
    import apb_i2c_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter logic [31:0] CTRL_ADDR   = CTRL_ADDR_DEF,
    parameter logic [31:0] DATA_ADDR   = DATA_ADDR_DEF,
    parameter logic [7:0]  CON1_DEF    = CON1_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 2048
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_rw,
    input  logic [7*NREQ-1:0]  req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [31:0]        rdata,
    output logic               err,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWrite,
    output logic [31:0]        PADDR,
    output logic [31:0]        PWDATA,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

    state_t            state, state_d;
    logic [NREQ-1:0]   gnt_d, done_d, arb_gnt;
    logic [31:0]       rdata_d, paddr_d, pwdata_d, sel_wdata;
    logic              err_d, psel_d, penable_d, pwrite_d;
    logic [IW-1:0]     owner, owner_d, rr_ptr, rr_ptr_d, arb_idx, sel;
    logic              owner_rw, owner_rw_d, sel_rw, to_resp, tmo_c;
    logic [6:0]        sel_addr;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt_c (arb_gnt),
        .idx_c (arb_idx)
    );

    // In IDLE the winner is not yet registered, so sample through the arbiter index.
    assign sel = (state == IDLE) ? arb_idx : owner;

    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IW'(i)) begin
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[i*7 +: 7];
                sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

`ifdef APB_I2C_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          access;

    assign access = (state == CACCESS) || (state == DACCESS);
    assign tmo_c  = access && !PREADY && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt <= '0;
        end else if (access && !PREADY && !tmo_c) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    logic unused_tmo;
    assign tmo_c      = 1'b0;
    assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWrite   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            owner    <= '0;
            owner_rw <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            done     <= done_d;
            rdata    <= rdata_d;
            err      <= err_d;
            PSEL     <= psel_d;
            PENABLE  <= penable_d;
            PWrite   <= pwrite_d;
            PADDR    <= paddr_d;
            PWDATA   <= pwdata_d;
            owner    <= owner_d;
            owner_rw <= owner_rw_d;
            rr_ptr   <= rr_ptr_d;
        end
    end

    // Next-state and next-output logic; outputs are registered to match the state they belong to.
    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        done_d     = '0;
        rdata_d    = rdata;
        err_d      = err;
        psel_d     = PSEL;
        penable_d  = PENABLE;
        pwrite_d   = PWrite;
        paddr_d    = PADDR;
        pwdata_d   = PWDATA;
        owner_d    = owner;
        owner_rw_d = owner_rw;
        rr_ptr_d   = rr_ptr;
        to_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d    = CSETUP;
                    gnt_d      = arb_gnt;
                    owner_d    = arb_idx;
                    owner_rw_d = sel_rw;
                    rr_ptr_d   = (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + IW'(1);
                    err_d      = 1'b0;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    pwrite_d   = 1'b1;
                    paddr_d    = CTRL_ADDR;
                    pwdata_d   = 32'(build_ctrl(sel_rw, sel_addr, CON1_DEF));
                end
            end
            CSETUP: begin
                state_d   = CACCESS;
                penable_d = 1'b1;
            end
            CACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        err_d   = 1'b1;
                        to_resp = 1'b1;
                    end else begin
                        state_d   = DSETUP;
                        penable_d = 1'b0;
                        paddr_d   = DATA_ADDR;
                        pwrite_d  = !owner_rw;
                        pwdata_d  = owner_rw ? '0 : sel_wdata;
                    end
                end else if (tmo_c) begin
                    err_d   = 1'b1;
                    to_resp = 1'b1;
                end
            end
            DSETUP: begin
                state_d   = DACCESS;
                penable_d = 1'b1;
            end
            DACCESS: begin
                if (PREADY) begin
                    err_d   = PSLVERR;
                    to_resp = 1'b1;
                    if (owner_rw) begin
                        rdata_d = PRDATA;
                    end
                end else if (tmo_c) begin
                    err_d   = 1'b1;
                    to_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (to_resp) begin
            state_d   = RESP;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            gnt_d     = '0;
            done_d    = gnt;
        end
    end

endmodule
